// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encodings and round-transform functions
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    localparam logic [3:0] IDLE           = 4'd0;
    localparam logic [3:0] INIT           = 4'd1;
    localparam logic [3:0] INV_SHIFT_ROW  = 4'd2;
    localparam logic [3:0] INV_SUB_0      = 4'd3;
    localparam logic [3:0] INV_SUB_1      = 4'd4;
    localparam logic [3:0] INV_SUB_2      = 4'd5;
    localparam logic [3:0] INV_SUB_3      = 4'd6;
    localparam logic [3:0] INV_SUB        = 4'd3;
    localparam logic [3:0] KEY_ADD        = 4'd7;
    localparam logic [3:0] INV_MIX_COLUMN = 4'd8;
    localparam logic [3:0] DONE           = 4'd9;

    function automatic logic [7:0] gm2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] a);
        return gm2(a) ^ a;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] a);
        return gm2(gm2(gm2(a))) ^ a;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] a);
        return gm2(gm2(gm2(a))) ^ gm2(a) ^ a;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] a);
        return gm2(gm2(gm2(a))) ^ gm2(gm2(a)) ^ a;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] a);
        return gm2(gm2(gm2(a))) ^ gm2(gm2(a)) ^ gm2(a);
    endfunction

    // Byte n of the state is bits 127-8n; byte 4c+r sits at row r, column c.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0] w;
        for (int c = 0; c < 4; c++) begin
            w = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gm2(w[31:24]) ^ gm3(w[23:16]) ^ w[15:8] ^ w[7:0],
                w[31:24] ^ gm2(w[23:16]) ^ gm3(w[15:8]) ^ w[7:0],
                w[31:24] ^ w[23:16] ^ gm2(w[15:8]) ^ gm3(w[7:0]),
                gm3(w[31:24]) ^ w[23:16] ^ w[15:8] ^ gm2(w[7:0])
            };
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0] w;
        for (int c = 0; c < 4; c++) begin
            w = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gm14(w[31:24]) ^ gm11(w[23:16]) ^ gm13(w[15:8]) ^ gm9(w[7:0]),
                gm9(w[31:24]) ^ gm14(w[23:16]) ^ gm11(w[15:8]) ^ gm13(w[7:0]),
                gm13(w[31:24]) ^ gm9(w[23:16]) ^ gm14(w[15:8]) ^ gm11(w[7:0]),
                gm11(w[31:24]) ^ gm13(w[23:16]) ^ gm9(w[15:8]) ^ gm14(w[7:0])
            };
        end
        return o;
    endfunction

    function automatic logic [127:0] addroundkey(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_decryption_inv_sbox.sv
// aes_inv_sbox: combinational 32-bit word through four FIPS-197 inverse S-box lookups
module aes_inv_sbox (
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sub_word = {INV_SBOX[word[31:24]], INV_SBOX[word[23:16]], INV_SBOX[word[15:8]], INV_SBOX[word[7:0]]};

endmodule

// File: rtl/aes_decryption.sv
// aes_decryption: iterative AES-128 inverse cipher; define AES_DEC_SBOX_PARALLEL_EN for four S-boxes (41-cycle latency)
module aes_decryption #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         next,
    input  logic         key_ready,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] input_block,
    output logic [127:0] output_block,
    output logic         block_ready,
    output logic         busy
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    logic [3:0]   state;
    logic [127:0] blk;
    logic [127:0] blk_sub;

`ifdef AES_DEC_SBOX_PARALLEL_EN
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .word     (blk[32*i +: 32]),
            .sub_word (blk_sub[32*i +: 32])
        );
    end
`else
    logic [1:0]  sub_slot;
    logic [31:0] sub_word;

    // INV_SUB_0 (word 0, bits 127:96) maps to slot 3 down to INV_SUB_3 at slot 0
    assign sub_slot = 2'd2 - state[1:0];

    aes_inv_sbox u_inv_sbox (
        .word     (blk[32*sub_slot +: 32]),
        .sub_word (sub_word)
    );

    // Splice the substituted word back into its slot, other words held
    always_comb begin
        blk_sub = blk;
        blk_sub[32*sub_slot +: 32] = sub_word;
    end
`endif

    assign busy = state != IDLE;

    // Round FSM: rk10 whitening, nine full inverse rounds, then a final round without InvMixColumns
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            round        <= LAST_ROUND;
            blk          <= '0;
            output_block <= '0;
            block_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (next && key_ready) begin
                    state       <= INIT;
                    block_ready <= 1'b0;
                end
                INIT: begin
                    blk   <= addroundkey(input_block, round_key);
                    round <= round - 4'd1;
                    state <= INV_SHIFT_ROW;
                end
                INV_SHIFT_ROW: begin
                    blk   <= inv_shiftrows(blk);
                    state <= INV_SUB_0;
                end
`ifdef AES_DEC_SBOX_PARALLEL_EN
                INV_SUB: begin
                    blk   <= blk_sub;
                    state <= KEY_ADD;
                end
`else
                INV_SUB_0, INV_SUB_1, INV_SUB_2: begin
                    blk   <= blk_sub;
                    state <= state + 4'd1;
                end
                INV_SUB_3: begin
                    blk   <= blk_sub;
                    state <= KEY_ADD;
                end
`endif
                KEY_ADD: begin
                    blk <= addroundkey(blk, round_key);
                    if (round == 4'd0) begin
                        state <= DONE;
                    end else begin
                        round <= round - 4'd1;
                        state <= INV_MIX_COLUMN;
                    end
                end
                INV_MIX_COLUMN: begin
                    blk   <= inv_mixcolumns(blk);
                    state <= INV_SHIFT_ROW;
                end
                DONE: begin
                    output_block <= blk;
                    block_ready  <= 1'b1;
                    round        <= LAST_ROUND;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
